// File: rtl/hazard_pkg.sv
// hazard_pkg: shared types and constants for the pipeline hazard controller.
package hazard_pkg;
    typedef enum logic [1:0] {RUN = 2'd0, MEM_WAIT = 2'd1, TRAP = 2'd2} state_e;
    localparam logic [4:0] REG_ZERO   = 5'd0;
    localparam logic [2:0] PRI_NONE   = 3'd0;
    localparam logic [2:0] PRI_HAZARD = 3'd1;
    localparam logic [2:0] PRI_BRANCH = 3'd2;
    localparam logic [2:0] PRI_MEM    = 3'd3;
    localparam logic [2:0] PRI_TRAP   = 3'd4;
    function automatic logic src_hit(input logic [4:0] src, input logic [4:0] dest);
        return src != REG_ZERO && src == dest;
    endfunction
endpackage

// File: rtl/pipeline_hazard_ctrl_detect.sv
// hazard_detect: combinational RAW check of ID sources against EXE/MEM destinations.
module hazard_detect import hazard_pkg::*; (
    input  logic       forward_en_i,
    input  logic [4:0] src1_i,
    input  logic [4:0] src2_i,
    input  logic       two_regs_i,
    input  logic [4:0] exe_dest_i,
    input  logic       exe_wb_en_i,
    input  logic       exe_mem_read_i,
    input  logic [4:0] mem_dest_i,
    input  logic       mem_wb_en_i,
    output logic       hazard_o
);
    logic exe_hit, mem_hit;
    assign exe_hit = src_hit(src1_i, exe_dest_i) || (two_regs_i && src_hit(src2_i, exe_dest_i));
    assign mem_hit = src_hit(src1_i, mem_dest_i) || (two_regs_i && src_hit(src2_i, mem_dest_i));
    // With forwarding only a load in EXE cannot be bypassed in time.
    assign hazard_o = forward_en_i ? (exe_hit && exe_mem_read_i)
                                   : ((exe_hit && exe_wb_en_i) || (mem_hit && mem_wb_en_i));
endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: stall/flush sequencer with memory-wait FSM and saturating counters.
module pipeline_hazard_ctrl import hazard_pkg::*; #(
    parameter int CNT_W       = 16,
    parameter int MEM_TIMEOUT = 255
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             forward_en_i,
    input  logic [4:0]       src1_i,
    input  logic [4:0]       src2_i,
    input  logic             two_regs_i,
    input  logic [4:0]       exe_dest_i,
    input  logic             exe_wb_en_i,
    input  logic             exe_mem_read_i,
    input  logic [4:0]       mem_dest_i,
    input  logic             mem_wb_en_i,
    input  logic             branch_taken_i,
    input  logic             mem_req_i,
    input  logic             mem_ready_i,
    input  logic             cnt_clear_i,
    output logic             pc_freeze_o,
    output logic             ifid_freeze_o,
    output logic             idexe_freeze_o,
    output logic             exemem_freeze_o,
    output logic             ifid_flush_o,
    output logic             idexe_flush_o,
    output logic             mem_error_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o,
    output logic [CNT_W-1:0] memwait_cnt_o
);
    localparam logic [CNT_W-1:0] TIMEOUT = CNT_W'(MEM_TIMEOUT);
    state_e           state_q, state_d;
    logic [CNT_W-1:0] wait_q, wait_d, stall_q, stall_d, flush_q, flush_d, memw_q, memw_d;
    logic             mem_error_q, mem_error_d, hazard, mem_hold;
    logic [2:0]       pri;
    hazard_detect u_detect (
        .forward_en_i   (forward_en_i),
        .src1_i         (src1_i),
        .src2_i         (src2_i),
        .two_regs_i     (two_regs_i),
        .exe_dest_i     (exe_dest_i),
        .exe_wb_en_i    (exe_wb_en_i),
        .exe_mem_read_i (exe_mem_read_i),
        .mem_dest_i     (mem_dest_i),
        .mem_wb_en_i    (mem_wb_en_i),
        .hazard_o       (hazard)
    );
    // Reset gates the Mealy outputs so they drop immediately regardless of inputs.
    always_comb begin
        mem_hold = !mem_ready_i && (state_q == MEM_WAIT || (state_q == RUN && mem_req_i));
        pri = !rst_n_i          ? PRI_NONE   :
              state_q == TRAP   ? PRI_TRAP   :
              mem_hold          ? PRI_MEM    :
              branch_taken_i    ? PRI_BRANCH :
              hazard            ? PRI_HAZARD : PRI_NONE;
    end
    assign pc_freeze_o     = pri == PRI_MEM || pri == PRI_HAZARD;
    assign ifid_freeze_o   = pc_freeze_o;
    assign idexe_freeze_o  = pri == PRI_MEM;
    assign exemem_freeze_o = pri == PRI_MEM;
    assign ifid_flush_o    = pri == PRI_BRANCH || pri == PRI_TRAP;
    assign idexe_flush_o   = ifid_flush_o || pri == PRI_HAZARD;
    assign mem_error_o     = mem_error_q;
    assign stall_cnt_o     = stall_q;
    assign flush_cnt_o     = flush_q;
    assign memwait_cnt_o   = memw_q;
    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        if (state_q == RUN && mem_req_i && !mem_ready_i) begin
            state_d = MEM_WAIT;
            wait_d  = '0;
        end else if (state_q == MEM_WAIT) begin
            wait_d  = wait_q + 1'b1;
            state_d = mem_ready_i ? RUN : (wait_d == TIMEOUT) ? TRAP : MEM_WAIT;
        end else if (state_q == TRAP) begin
            state_d = RUN;
        end
        mem_error_d = mem_error_q || state_d == TRAP;
        stall_d = cnt_clear_i ? '0 : (pri == PRI_HAZARD && stall_q != '1) ? stall_q + 1'b1 : stall_q;
        flush_d = cnt_clear_i ? '0 : (pri == PRI_BRANCH && flush_q != '1) ? flush_q + 1'b1 : flush_q;
        memw_d  = cnt_clear_i ? '0 : (pri == PRI_MEM && memw_q != '1) ? memw_q + 1'b1 : memw_q;
    end
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q     <= RUN;
            wait_q      <= '0;
            mem_error_q <= 1'b0;
            stall_q     <= '0;
            flush_q     <= '0;
            memw_q      <= '0;
        end else begin
            state_q     <= state_d;
            wait_q      <= wait_d;
            mem_error_q <= mem_error_d;
            stall_q     <= stall_d;
            flush_q     <= flush_d;
            memw_q      <= memw_d;
        end
    end
endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Central stall/flush sequencer for the 5-stage pipeline. Each cycle it decides whether the PC and IF/ID register freeze, whether ID/EXE receives a bubble (flush), and whether IF/ID is squashed on a taken branch. It also holds the whole pipeline while a data-memory access waits for its ready handshake, and keeps saturating performance counters. It sits beside the ID/EXE pipeline register and drives that register's `flush` input plus the freeze inputs of the other stage registers.

## Interface
- `CNT_W`, 16: width of each performance counter.
- `MEM_TIMEOUT`, 255: maximum MEM_WAIT cycles before the error trap (1..2^CNT_W-1).
- `clock` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-low.
- `forward_en` in 1: 1 = forwarding unit present; only load-use stalls.
- `src1`, `src2` in 5: ID-stage source registers.
- `two_regs` in 1: ID instruction reads `src2`.
- `exe_dest` in 5, `exe_wb_en` in 1, `exe_mem_read` in 1: ID/EXE register outputs.
- `mem_dest` in 5, `mem_wb_en` in 1: EXE/MEM register outputs.
- `branch_taken` in 1: EXE-stage branch resolved taken.
- `mem_req` in 1, `mem_ready` in 1: data-memory access in flight / completes this cycle.
- `cnt_clear` in 1: synchronous clear of all counters.
- `pc_freeze`, `ifid_freeze` out 1: hold PC / IF/ID.
- `idexe_freeze`, `exemem_freeze` out 1: hold ID/EXE / EXE/MEM (memory wait only).
- `ifid_flush`, `idexe_flush` out 1: zero IF/ID / ID/EXE on next edge.
- `mem_error` out 1: sticky; memory timeout occurred.
- `stall_cnt`, `flush_cnt`, `memwait_cnt` out CNT_W: hazard-stall, branch-flush, and memory-wait cycle counts.

## Operation
- Register 0 never causes a hazard. `src2` is compared only when `two_regs`=1.
- `forward_en`=0 → hazard when a source matches `exe_dest` with `exe_wb_en`, or matches `mem_dest` with `mem_wb_en`.
- `forward_en`=1 → hazard only when a source matches `exe_dest` with `exe_mem_read`.
- FSM states:
  - RUN → MEM_WAIT when `mem_req`=1 and `mem_ready`=0.
  - MEM_WAIT → RUN when `mem_ready`=1.
  - MEM_WAIT → TRAP when the wait counter reaches `MEM_TIMEOUT`.
  - TRAP → RUN next cycle; sets `mem_error`.
- Output priority, highest first:
  1. MEM_WAIT, or RUN with `mem_req`&!`mem_ready`: all four freezes = 1, no flush. A pending branch or hazard is re-evaluated after release.
  2. `branch_taken`: `ifid_flush`=`idexe_flush`=1, freezes 0. A simultaneous hazard is ignored.
  3. Hazard: `pc_freeze`=`ifid_freeze`=`idexe_flush`=1.
  4. Otherwise all 0.
- TRAP: freezes 0. Flushes all 1, to squash the faulting sequence.
- Counters saturate at all-ones. Each increments once per cycle its condition holds: priority-3 cycles for `stall_cnt`, priority-2 for `flush_cnt`, priority-1 for `memwait_cnt`.
- `cnt_clear` wins over increment. `mem_error` is cleared only by reset.

## Timing
- Control outputs are combinational (Mealy) from the current state and inputs. A hazard is acted on in the same cycle it appears.
- Load-use: exactly 1 bubble. Non-forwarding mode: 1-2 bubbles depending on the stage distance.
- Memory wait: if `mem_ready` rises in cycle N, the freezes drop in cycle N.
- The wait counter resets on entering MEM_WAIT. TRAP is entered on the edge where the count equals `MEM_TIMEOUT`.
- Reset asserted, including mid-MEM_WAIT: state = RUN, all counters 0, `mem_error`=0, all freeze/flush outputs 0 immediately (asynchronous), regardless of inputs.

## Structure
- Shared package `hazard_pkg`: the state enum (RUN, MEM_WAIT, TRAP), the `REG_ZERO` constant, and priority encoding constants.
- Sub-module `hazard_detect`: pure combinational source/dest comparison producing `hazard`. The FSM, priority mux and counters stay in the top.

## Test plan
- `forward_en`=1, `exe_mem_read`=1, `exe_dest`=5, `src1`=5 → one cycle with `pc_freeze`=`ifid_freeze`=`idexe_flush`=1; `stall_cnt`=1.
- `forward_en`=0, `mem_wb_en`=1, `mem_dest`=7, `src2`=7, `two_regs`=0 → no stall. Same with `two_regs`=1 → stall. `src1`=`exe_dest`=0 → no stall.
- `branch_taken`=1 together with a load-use hazard → `ifid_flush`=`idexe_flush`=1, `pc_freeze`=0; `flush_cnt`=1, `stall_cnt`=0.
- `mem_req`=1 with `mem_ready` low for 3 cycles → all freezes high 3 cycles, released the cycle `mem_ready`=1; `memwait_cnt`=3.
- `MEM_TIMEOUT`=4, `mem_ready` held 0 → TRAP after 4 wait cycles, one cycle of both flushes, `mem_error`=1 stays set until reset.
- Reset asserted during MEM_WAIT → outputs 0 immediately, counters 0; after release with `mem_ready`=1 the FSM is in RUN.
